uart_transmitter: RTL and testbench

//  Serialises one byte per TX_EN pulse onto the UART line: 1 start, 8 data (LSB first),

---
 rtl/uart_transmitter_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_transmitter.sv | 143 ++++++++++++++
 tb/tb_uart_transmitter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmit path: FSM state encodings, parity mode
// codes and the clocks-per-bit computation reused by the receiver.
package uart_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Clocks per bit; integer division, caller guarantees the result is >= 2.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Parity bit appended after the data bits for the given mode.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        if (mode == PARITY_ODD) begin
            return ~^data;
        end
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..DIV-1 while enabled and pulses tick in the last cycle
// of each bit. A clear restarts the period so a new frame is aligned to its accept edge.
module uart_baud_tick #(
    parameter int DIV = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per accepted TX_EN, framed as start, 8 data bits LSB
// first, optional parity, stop. Line and status are driven straight from flops.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int PARITY   = 0
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] TX_DATA,
    input  logic       TX_EN,
    output logic       TX_STATUS,
    output logic       UART_TX,
    output logic [2:0] dbg_state_o
);

    localparam int DIV        = calc_div(CLK_FREQ, BAUD);
    localparam bit HAS_PARITY = (PARITY != PARITY_NONE);

    // Handshake: a byte is taken on any rising edge where TX_EN=1 and TX_STATUS=1;
    // TX_STATUS drops on that same edge and rises again on the edge that ends the stop bit.

    tx_state_e  state_q,   state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q,   shift_d;
    logic       parity_q,  parity_d;
    logic       tx_q,      tx_d;
    logic       status_q,  status_d;
    logic       accept;
    logic       tick;
    logic       busy;

    assign busy = (state_q != ST_IDLE);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud (
        .clk_i  (sysclk),
        .rst_i  (reset),
        .clr_i  (accept),
        .en_i   (busy),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        status_d  = status_q;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d     = 1'b1;
                status_d = 1'b1;
                if (TX_EN) begin
                    accept    = 1'b1;
                    shift_d   = TX_DATA;
                    parity_d  = HAS_PARITY ? parity_bit(TX_DATA, PARITY) : 1'b0;
                    bit_idx_d = 3'd0;
                    tx_d      = 1'b0;
                    status_d  = 1'b0;
                    state_d   = ST_START;
                end
            end

            ST_START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end

            // The shift register always presents the current bit at [0], so the
            // next bit to drive is [1] just before shifting.
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        if (HAS_PARITY) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end

            ST_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (tick) begin
                    tx_d     = 1'b1;
                    status_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                tx_d     = 1'b1;
                status_d = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            status_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            status_q  <= status_d;
        end
    end

    assign UART_TX     = tx_q;
    assign TX_STATUS   = status_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter at DIV=16 with three instances (no/even/odd parity)
// sharing the same stimulus; frames are checked cycle by cycle against hand-built bit patterns.
module tb_uart_transmitter;

  localparam int BIT = 16;

  logic       sysclk;
  logic       reset;
  logic [7:0] TX_DATA;
  logic       TX_EN;
  logic [2:0] tx_v;
  logic [2:0] st_v;
  logic [2:0] dbg0, dbg1, dbg2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0]  data;
    logic [9:0]  exp_p0;  // frame bits, bit 0 = first on the line
    logic [10:0] exp_p1;
    logic [10:0] exp_p2;
    int          poke;    // cycle of a second TX_EN with 8'hFF, 0 = none
    int          tail;    // idle cycles checked after the longest frame
  } vec_t;

  vec_t vecs [4];
  vec_t v81;

  uart_transmitter #(.CLK_FREQ(160), .BAUD(10), .PARITY(0)) u_p0 (
    .sysclk(sysclk), .reset(reset), .TX_DATA(TX_DATA), .TX_EN(TX_EN),
    .TX_STATUS(st_v[0]), .UART_TX(tx_v[0]), .dbg_state_o(dbg0));
  uart_transmitter #(.CLK_FREQ(160), .BAUD(10), .PARITY(1)) u_p1 (
    .sysclk(sysclk), .reset(reset), .TX_DATA(TX_DATA), .TX_EN(TX_EN),
    .TX_STATUS(st_v[1]), .UART_TX(tx_v[1]), .dbg_state_o(dbg1));
  uart_transmitter #(.CLK_FREQ(160), .BAUD(10), .PARITY(2)) u_p2 (
    .sysclk(sysclk), .reset(reset), .TX_DATA(TX_DATA), .TX_EN(TX_EN),
    .TX_STATUS(st_v[2]), .UART_TX(tx_v[2]), .dbg_state_o(dbg2));

  // clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Watch all instances for n cycles; every sample must be line=1, status=1.
  task automatic check_idle(input string name, input int n);
    logic bad [3];
    for (int i = 0; i < 3; i++) bad[i] = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge sysclk);
      for (int i = 0; i < 3; i++)
        if (tx_v[i] !== 1'b1 || st_v[i] !== 1'b1) bad[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("%s inst%0d idle", name, i), 32'(bad[i]), 32'd0);
  endtask

  // One frame on all instances, accepted at edge k; cycle c lies between edges k+c-1 and k+c.
  task automatic run_frame(input vec_t v);
    logic [10:0] exp [3];
    logic [10:0] mid [3];
    logic [10:0] bad [3];
    int          flen [3];
    int          low [3];
    logic        idle_bad [3];
    int          bi;
    exp[0] = {1'b0, v.exp_p0};
    exp[1] = v.exp_p1;
    exp[2] = v.exp_p2;
    flen[0] = 160; flen[1] = 176; flen[2] = 176;
    for (int i = 0; i < 3; i++) begin
      mid[i] = '0; bad[i] = '0; low[i] = 0; idle_bad[i] = 1'b0;
    end
    @(negedge sysclk);
    TX_DATA = v.data;
    TX_EN   = 1'b1;
    @(posedge sysclk);
    for (int c = 1; c <= 176 + v.tail; c++) begin
      @(negedge sysclk);
      TX_EN   = (c == v.poke);
      TX_DATA = (c == v.poke) ? 8'hFF : ~v.data;
      for (int i = 0; i < 3; i++) begin
        if (c <= flen[i]) begin
          bi = (c - 1) / BIT;
          if (tx_v[i] !== exp[i][bi]) bad[i][bi] = 1'b1;
          if ((c - 1) % BIT == BIT / 2) mid[i][bi] = tx_v[i];
          if (st_v[i] === 1'b0) low[i]++;
        end else if (tx_v[i] !== 1'b1 || st_v[i] !== 1'b1) begin
          idle_bad[i] = 1'b1;
        end
      end
    end
    TX_EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < flen[i] / BIT; b++)
        check($sformatf("%02h inst%0d bit%0d", v.data, i, b), 32'(mid[i][b]), 32'(exp[i][b]));
      check($sformatf("%02h inst%0d bits stable", v.data, i), 32'(bad[i]), 32'd0);
      check($sformatf("%02h inst%0d busy cycles", v.data, i), 32'(low[i]), 32'(flen[i]));
      check($sformatf("%02h inst%0d idle after", v.data, i), 32'(idle_bad[i]), 32'd0);
    end
  endtask

  // TX_EN held high: 8'h55 then 8'hAA on the no-parity instance.
  task automatic run_back_to_back();
    logic [9:0] f1, f2;
    logic [9:0] mid1, mid2, bad1, bad2;
    int high_cnt, low_cnt, bi;
    logic idle_bad;
    f1 = 10'b1_01010101_0;
    f2 = 10'b1_10101010_0;
    mid1 = '0; mid2 = '0; bad1 = '0; bad2 = '0;
    high_cnt = 0; low_cnt = 0; idle_bad = 1'b0;
    @(negedge sysclk);
    TX_DATA = 8'h55;
    TX_EN   = 1'b1;
    @(posedge sysclk);
    for (int c = 1; c <= 360; c++) begin
      @(negedge sysclk);
      if (c == 1) TX_DATA = 8'hAA;
      if (c == 162) TX_EN = 1'b0;
      if (c <= 321) begin
        if (st_v[0] === 1'b1) high_cnt++;
        else if (st_v[0] === 1'b0) low_cnt++;
      end
      if (c <= 160) begin
        bi = (c - 1) / BIT;
        if (tx_v[0] !== f1[bi]) bad1[bi] = 1'b1;
        if ((c - 1) % BIT == BIT / 2) mid1[bi] = tx_v[0];
      end else if (c == 161) begin
        check("b2b gap status", 32'(st_v[0]), 32'd1);
        check("b2b gap line", 32'(tx_v[0]), 32'd1);
      end else if (c <= 321) begin
        bi = (c - 162) / BIT;
        if (tx_v[0] !== f2[bi]) bad2[bi] = 1'b1;
        if ((c - 162) % BIT == BIT / 2) mid2[bi] = tx_v[0];
      end else if (tx_v[0] !== 1'b1 || st_v[0] !== 1'b1) begin
        idle_bad = 1'b1;
      end
    end
    check("b2b frame1 bits", 32'(mid1), 32'(f1));
    check("b2b frame2 bits", 32'(mid2), 32'(f2));
    check("b2b frame1 stable", 32'(bad1), 32'd0);
    check("b2b frame2 stable", 32'(bad2), 32'd0);
    check("b2b busy cycles", 32'(low_cnt), 32'd320);
    check("b2b ready cycles", 32'(high_cnt), 32'd1);
    check("b2b idle after", 32'(idle_bad), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'b1_10100101_0, 11'b1_0_10100101_0, 11'b1_1_10100101_0, 0, 8};
    vecs[1] = '{8'h07, 10'b1_00000111_0, 11'b1_1_00000111_0, 11'b1_0_00000111_0, 0, 8};
    vecs[2] = '{8'h3C, 10'b1_00111100_0, 11'b1_0_00111100_0, 11'b1_1_00111100_0, 40, 40};
    vecs[3] = '{8'h01, 10'b1_00000001_0, 11'b1_1_00000001_0, 11'b1_0_00000001_0, 0, 8};
    v81     = '{8'h81, 10'b1_10000001_0, 11'b1_0_10000001_0, 11'b1_1_10000001_0, 0, 8};

    reset   = 1'b1;
    TX_EN   = 1'b0;
    TX_DATA = 8'h00;

    // reset held three cycles
    for (int r = 0; r < 3; r++) begin
      @(negedge sysclk);
      if (r == 0) begin
        check("reset line p0", 32'(tx_v[0]), 32'd1);
        check("reset status p0", 32'(st_v[0]), 32'd1);
        check("reset line p1", 32'(tx_v[1]), 32'd1);
        check("reset status p2", 32'(st_v[2]), 32'd1);
        check("reset state", 32'({dbg2, dbg1, dbg0}), 32'd0);
      end
    end
    reset = 1'b0;
    check_idle("post reset", 20);

    // directed frame table
    for (int t = 0; t < 4; t++) run_frame(vecs[t]);

    run_back_to_back();
    check_idle("after b2b", 4);

    // TX_EN coinciding with reset is dropped
    @(negedge sysclk);
    reset = 1'b1; TX_EN = 1'b1; TX_DATA = 8'h00;
    @(negedge sysclk);
    reset = 1'b0; TX_EN = 1'b0;
    check_idle("reset wins", 40);

    // reset at cycle 70 of a frame aborts it
    @(negedge sysclk);
    TX_DATA = 8'h3C; TX_EN = 1'b1;
    @(posedge sysclk);
    for (int c = 1; c <= 70; c++) begin
      @(negedge sysclk);
      TX_EN = 1'b0;
      if (c == 70) reset = 1'b1;
    end
    @(negedge sysclk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort inst%0d line", i), 32'(tx_v[i]), 32'd1);
      check($sformatf("abort inst%0d status", i), 32'(st_v[i]), 32'd1);
    end
    check_idle("after abort", 5);
    run_frame(v81);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
